// File: rtl/pixel_out_pipe.sv
// Display back-end: raster timing, early read coordinates to the colour source,
// latency-matched sync/DE, and RGB unpacking with blanking and a colour-bar override.
module pixel_out_pipe #(
  parameter int CORDW        = 10,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit SYNC_POL     = 1'b0,
  parameter int READ_LATENCY = 2,
  parameter int R_W          = 3,
  parameter int G_W          = 4,
  parameter int B_W          = 3,
  localparam int COLOR_W     = R_W + G_W + B_W
) (
  input  logic               clk_pix,
  input  logic               rst_pix_n,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               expand_mode,
  input  logic               pattern_en,
  output logic [CORDW-1:0]   read_x,
  output logic [CORDW-1:0]   read_y,
  output logic [CORDW-1:0]   sx,
  output logic [CORDW-1:0]   sy,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic [7:0]         r,
  output logic [7:0]         g,
  output logic [7:0]         b,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] HA_C   = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] HS0_C  = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HS1_C  = CORDW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] HMAX_C = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] VA_C   = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] VS0_C  = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VS1_C  = CORDW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CORDW-1:0] VMAX_C = CORDW'(V_TOTAL - 1);

  typedef struct packed {
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
    logic             de;
    logic             hs;
    logic             vs;
  } tim_t;

  localparam tim_t TIM_RST = '{x: '0, y: '0, de: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL};

  // Left-aligns a W-bit channel into 8 bits, filling the tail with zeros or
  // with the channel repeated MSB-first.
  function automatic logic [7:0] expand(input logic [7:0] c, input int w, input logic rep);
    logic [7:0] o;
    o = '0;
    for (int i = 0; i < 8; i++) begin
      if (rep)        o[3'(7-i)] = c[3'(w-1-(i%w))];
      else if (i < w) o[3'(7-i)] = c[3'(w-1-i)];
    end
    return o;
  endfunction

  logic [CORDW-1:0] cx_q, cx_d, cy_q, cy_d;
  tim_t             raw, dly;

  always_comb begin
    cx_d = cx_q + CORDW'(1);
    cy_d = cy_q;
    if (cx_q == HMAX_C) begin
      cx_d = '0;
      cy_d = (cy_q == VMAX_C) ? '0 : cy_q + CORDW'(1);
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign read_x = cx_q;
  assign read_y = cy_q;

  always_comb begin
    raw.x  = cx_q;
    raw.y  = cy_q;
    raw.de = (cx_q < HA_C) && (cy_q < VA_C);
    raw.hs = ((cx_q >= HS0_C) && (cx_q < HS1_C)) ? SYNC_POL : ~SYNC_POL;
    raw.vs = ((cy_q >= VS0_C) && (cy_q < VS1_C)) ? SYNC_POL : ~SYNC_POL;
  end

  // Timing rides alongside the colour source's read latency.
  generate
    if (READ_LATENCY == 0) begin : g_nopipe
      assign dly = raw;
    end else begin : g_pipe
      tim_t pipe_q [READ_LATENCY];
      always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
          for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= TIM_RST;
        end else begin
          pipe_q[0] <= raw;
          for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign dly = pipe_q[READ_LATENCY-1];
    end
  endgenerate

  logic [2:0] bar;
  logic [7:0] r_d, g_d, b_d;
  logic       fs_d;

  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++)
      if (32'(dly.x) * 8 >= k * H_ACTIVE) bar = 3'(k);
  end

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (dly.de) begin
      if (pattern_en) begin
        r_d = {8{bar[2]}};
        g_d = {8{bar[1]}};
        b_d = {8{bar[0]}};
      end else begin
        r_d = expand(8'(color_in[COLOR_W-1 -: R_W]), R_W, expand_mode);
        g_d = expand(8'(color_in[B_W +: G_W]),       G_W, expand_mode);
        b_d = expand(8'(color_in[B_W-1:0]),          B_W, expand_mode);
      end
    end
  end

  // Gated by DE so cleared pipeline stages (coordinate 0, DE low) never fire it.
  assign fs_d = dly.de && (dly.x == '0) && (dly.y == '0);

  logic [CORDW-1:0] sx_q, sy_q;
  logic             de_q, hs_q, vs_q, fs_q;
  logic [7:0]       r_q, g_q, b_q;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      sx_q <= '0;
      sy_q <= '0;
      de_q <= 1'b0;
      hs_q <= ~SYNC_POL;
      vs_q <= ~SYNC_POL;
      fs_q <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      sx_q <= dly.x;
      sy_q <= dly.y;
      de_q <= dly.de;
      hs_q <= dly.hs;
      vs_q <= dly.vs;
      fs_q <= fs_d;
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
    end
  end

  assign sx          = sx_q;
  assign sy          = sy_q;
  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;

endmodule

// File: tb/tb_pixel_out_pipe.sv
// Randomized bench: three pipes (read latency 2, 0, 5) on a reduced raster,
// each checked every cycle against a frame-position model of the display.
module tb_pixel_out_pipe;

  localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 24, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int NI = 3;
  localparam int RLS [NI] = '{2, 0, 5};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] col [NI];
  logic       mode = 1'b0, pat = 1'b0;
  logic [9:0] rx [NI], ry [NI], sx [NI], sy [NI];
  logic       de [NI], hs [NI], vs [NI], fs [NI];
  logic [7:0] r [NI], g [NI], b [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    pixel_out_pipe #(
      .CORDW(10), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0),
      .READ_LATENCY(RLS[gi]), .R_W(3), .G_W(4), .B_W(3)
    ) u_dut (
      .clk_pix(clk), .rst_pix_n(rst_n), .color_in(col[gi]),
      .expand_mode(mode), .pattern_en(pat),
      .read_x(rx[gi]), .read_y(ry[gi]), .sx(sx[gi]), .sy(sy[gi]),
      .de(de[gi]), .hsync(hs[gi]), .vsync(vs[gi]),
      .r(r[gi]), .g(g[gi]), .b(b[gi]), .frame_start(fs[gi])
    );
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Repeat the channel until it covers 8 bits, then keep the top 8.
  function automatic logic [7:0] m_exp(input int c, input int w, input bit rep);
    int acc, n;
    if (!rep) return 8'(c << (8 - w));
    acc = c;
    n   = w;
    while (n < 8) begin
      acc = (acc << w) | c;
      n  += w;
    end
    return 8'(acc >> (n - 8));
  endfunction

  function automatic logic [9:0] src_f(input logic [9:0] x, input logic [9:0] y);
    return {x[2:0], y[3:0], x[5:3]};
  endfunction

  int         e = 0;
  int         cyc = 0;
  logic [9:0] hist [NI][8];
  logic [9:0] p_col [NI];
  logic       p_mode = 1'b0, p_pat = 1'b0, p_src = 1'b0;
  bit         src_mode = 1'b1;
  logic [9:0] drv_col = '0;
  logic       drv_mode = 1'b0, drv_pat = 1'b0;
  bit         have_fs [NI];
  int         last_fs [NI], de_cnt [NI];

  task automatic check_inst(input int i, output bit efs);
    int rl, k, ox, oy, bar;
    bit act, ede, ehs, evs;
    logic [7:0] er, eg, eb;
    string t;
    rl = RLS[i];
    t  = $sformatf("L%0d", rl);
    k  = e % FT;
    chk({t, ".read_x"}, 32'(rx[i]), k % HT);
    chk({t, ".read_y"}, 32'(ry[i]), k / HT);
    act = (e >= rl + 1);
    k   = act ? (e - rl - 1) % FT : 0;
    ox  = k % HT;
    oy  = k / HT;
    ede = act && ox < HA && oy < VA;
    ehs = !(act && ox >= HA + HFP && ox < HA + HFP + HS);
    evs = !(act && oy >= VA + VFP && oy < VA + VFP + VS);
    efs = act && k == 0;
    er = '0; eg = '0; eb = '0;
    if (ede) begin
      if (p_pat) begin
        bar = ox * 8 / HA;
        er = bar[2] ? 8'hFF : 8'h00;
        eg = bar[1] ? 8'hFF : 8'h00;
        eb = bar[0] ? 8'hFF : 8'h00;
      end else begin
        er = m_exp(int'(p_col[i][9:7]), 3, p_mode);
        eg = m_exp(int'(p_col[i][6:3]), 4, p_mode);
        eb = m_exp(int'(p_col[i][2:0]), 3, p_mode);
      end
    end
    chk({t, ".sx"}, 32'(sx[i]), ox);
    chk({t, ".sy"}, 32'(sy[i]), oy);
    chk({t, ".de"}, 32'(de[i]), 32'(ede));
    chk({t, ".hsync"}, 32'(hs[i]), 32'(ehs));
    chk({t, ".vsync"}, 32'(vs[i]), 32'(evs));
    chk({t, ".frame_start"}, 32'(fs[i]), 32'(efs));
    chk({t, ".rgb"}, {8'h0, r[i], g[i], b[i]}, {8'h0, er, eg, eb});
    if (ede && p_src && !p_pat) begin
      chk({t, ".dec_x_lo"}, 32'(r[i][7:5]), ox & 7);
      chk({t, ".dec_y"},    32'(g[i][7:4]), oy & 15);
      chk({t, ".dec_x_hi"}, 32'(b[i][7:5]), (ox >> 3) & 7);
    end
    if (ede && !p_src && !p_pat && p_col[i] == 10'h2D3)
      chk({t, ".expand_dir"}, {8'h0, r[i], g[i], b[i]},
          p_mode ? 32'h00B6AA6D : 32'h00A0A060);
  endtask

  task automatic step();
    bit efs;
    @(posedge clk);
    if (rst_n) e++;
    cyc++;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_inst(i, efs);
      if (efs) begin
        if (have_fs[i]) begin
          chk($sformatf("L%0d.frame_de", RLS[i]), de_cnt[i], HA * VA);
          chk($sformatf("L%0d.frame_period", RLS[i]), cyc - last_fs[i], FT);
        end
        have_fs[i] = 1'b1;
        last_fs[i] = cyc;
        de_cnt[i]  = 0;
      end
      if (de[i] === 1'b1) de_cnt[i]++;
      for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = src_f(rx[i], ry[i]);
      col[i]   = src_mode ? hist[i][RLS[i]] : drv_col;
      p_col[i] = col[i];
    end
    mode   = drv_mode;
    pat    = drv_pat;
    p_mode = drv_mode;
    p_pat  = drv_pat;
    p_src  = src_mode;
  endtask

  task automatic rand_ctl(input int pat_odds);
    drv_mode = 1'($urandom_range(0, 1));
    drv_pat  = ($urandom_range(0, pat_odds) == 0);
    drv_col  = 10'($urandom);
  endtask

  initial begin
    bit dummy;
    bit found;
    for (int i = 0; i < NI; i++) begin
      col[i] = '0;
      p_col[i] = '0;
      have_fs[i] = 1'b0;
      last_fs[i] = 0;
      de_cnt[i] = 0;
      for (int k = 0; k < 8; k++) hist[i][k] = '0;
    end

    repeat (3) step();
    rst_n = 1'b1;

    src_mode = 1'b1;
    repeat (FT + 300) begin rand_ctl(7); step(); end

    src_mode = 1'b0;
    repeat (500) begin rand_ctl(3); step(); end

    drv_col = 10'h2D3;
    drv_pat = 1'b0;
    drv_mode = 1'b0;
    repeat (700) step();
    drv_mode = 1'b1;
    repeat (700) step();

    drv_pat = 1'b1;
    repeat (400) begin drv_mode = 1'($urandom_range(0, 1)); drv_col = 10'($urandom); step(); end

    src_mode = 1'b1;
    found = 1'b0;
    for (int n = 0; n < FT && !found; n++) begin
      rand_ctl(7);
      step();
      found = ((e % FT) == 10 * HT + 30);
    end
    chk("midframe_reach", 32'(found), 32'd1);

    rst_n = 1'b0;
    #1;
    e = 0;
    for (int i = 0; i < NI; i++) begin
      check_inst(i, dummy);
      have_fs[i] = 1'b0;
      de_cnt[i]  = 0;
    end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (FT + 300) begin rand_ctl(7); step(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_out_pipe.md
Name: pixel_out_pipe

Overview:
- Parametrised display back-end that replaces the fixed 480p timing plus hard-wired colour slicing in the pixel path.
- Generates VGA-style timing and issues read coordinates to the colour source (raymarcher frame buffer) ahead of time.
- Delays sync, data-enable and coordinates to match the source's read latency.
- Unpacks packed RGB of configurable widths into 8-bit channels (zero-pad or bit-replicate), with blanking and a test-pattern override.

Parameters:
- CORDW, 10, coordinate width.
- H_ACTIVE, 640, active pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, active lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.
- SYNC_POL, 0, sync asserted level: 0 = active-low, 1 = active-high.
- READ_LATENCY, 2, cycles from read_x/read_y to valid color_in; legal range 0..7.
- R_W, 3, red bits in color_in; legal range 1..8.
- G_W, 4, green bits; legal range 1..8.
- B_W, 3, blue bits; legal range 1..8.
- COLOR_W, derived localparam, R_W+G_W+B_W.

Ports:
- clk_pix, in, 1: pixel clock; sole clock.
- rst_pix_n, in, 1: asynchronous active-low reset.
- color_in, in, COLOR_W: packed colour {red MSBs, green, blue LSBs}.
- expand_mode, in, 1: 0 = zero-pad, 1 = bit-replicate.
- pattern_en, in, 1: substitute colour bars for color_in.
- read_x, out, CORDW: raw horizontal counter to colour source.
- read_y, out, CORDW: raw vertical counter to colour source.
- sx, out, CORDW: output-aligned horizontal position.
- sy, out, CORDW: output-aligned vertical position.
- de, out, 1: output-aligned data enable.
- hsync, out, 1: output-aligned hsync.
- vsync, out, 1: output-aligned vsync.
- r, out, 8: red channel.
- g, out, 8: green channel.
- b, out, 8: blue channel.
- frame_start, out, 1: one-cycle pulse when the output is at (0,0).

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Raw counters cx/cy reset to 0.
  - cx increments every cycle and wraps H_TOTAL-1 -> 0.
  - On that wrap cy increments and wraps V_TOTAL-1 -> 0.
  - There is no stall input.
- read_x = cx, read_y = cy, driven directly from registers.
- Raw decode:
  - de_raw = (cx < H_ACTIVE) && (cy < V_ACTIVE).
  - hs_raw active when H_ACTIVE+H_FP <= cx < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw active when V_ACTIVE+V_FP <= cy < V_ACTIVE+V_FP+V_SYNC.
  - Active level is SYNC_POL.
- Alignment: a READ_LATENCY-deep shift register carries {cx, cy, de_raw, hs_raw, vs_raw}.
  - At edge t+READ_LATENCY+1, the output registers capture color_in sampled at t+READ_LATENCY together with timing from t.
  - Total latency from counter to output is READ_LATENCY+1 cycles.
  - With READ_LATENCY = 0 the shift register degenerates to wires; the output stays registered.
- Expansion, per channel of width W:
  - Zero-pad: {c, (8-W) zeros}.
  - Replicate: c repeated MSB-first and truncated to 8 bits. Example: W=3, 101 -> 0xB6; W=4, 1010 -> 0xAA.
  - W=8 passes through unchanged in both modes.
  - expand_mode is sampled in the same cycle as color_in; no glitch protection.
- Pattern: when pattern_en = 1, bar index i = (delayed sx * 8) / H_ACTIVE, range 0..7.
  - r = i[2] ? 0xFF : 0x00.
  - g = i[1] ? 0xFF : 0x00.
  - b = i[0] ? 0xFF : 0x00.
  - pattern_en is sampled in the same cycle as color_in.
- Blanking: when delayed de = 0, r/g/b are forced to 0 regardless of pattern_en or color_in.
- frame_start = 1 for exactly one cycle, when the delayed sx = 0 and sy = 0.
- Reset values of all outputs:
  - sx = sy = 0; read_x = read_y = 0.
  - de = 0, frame_start = 0.
  - hsync = vsync = ~SYNC_POL (inactive).
  - r = g = b = 0.
  - All shift-register stages are cleared to de = 0, inactive syncs, coordinate 0.
- Reset mid-frame: outputs return to reset values immediately (asynchronous).
  - After release, cx/cy restart at (0,0).
  - The first frame_start occurs READ_LATENCY+1 edges after the first active clock edge.
  - No stale pixel with de = 1 may appear in between.

Test Plan:
1. Reset: hold rst_pix_n = 0, toggle clk_pix -> all outputs at reset values, hsync = vsync = 1 (SYNC_POL=0). Release -> read_x counts 0,1,2,…; frame_start high exactly at edge READ_LATENCY+1.
2. Latency: colour-source model returns color_in = {read_x[2:0], read_y[3:0], read_x[5:3]} after READ_LATENCY = 2 cycles -> at every output cycle with de = 1, the colour decodes back to the same sx/sy; repeat with READ_LATENCY = 0 and 5.
3. Expansion: color_in = 10'b101_1010_011 (R_W=3, G_W=4, B_W=3).
   - Zero-pad -> r = 0xA0, g = 0xA0, b = 0x60.
   - Replicate -> r = 0xB6, g = 0xAA, b = 0x6D.
4. Timing, defaults:
   - hsync low for 96 cycles starting at sx = 656; line period 800.
   - vsync low for 2 lines starting at sy = 490; frame period 420000 cycles.
   - de high for 640 x 480 cycles per frame.
   - Wrap sx 799 -> 0 with sy 524 -> 0, producing frame_start.
5. Pattern/blanking: pattern_en = 1 -> sx = 0..79 outputs 000000, sx = 560..639 outputs FFFFFF; sx = 700 outputs 0 in any mode.
6. Mid-frame reset: assert rst_pix_n = 0 at sx = 300, sy = 200 -> outputs clear in the same cycle. Release -> no de = 1 before the first frame_start, and the next frame timing is identical to test 4.
